// File: rtl/board_ram_arbiter_if.sv
// Bundle of the game port, video port and RAM command pins of the board RAM arbiter.
// slave is the arbiter side; master is the side that owns the game FSM, display and RAM.
interface board_ram_arbiter_if;
    logic       g_req;
    logic       g_we;
    logic [4:0] g_x;
    logic [3:0] g_y;
    logic [3:0] g_wdata;
    logic       g_ack;
    logic       g_rvalid;
    logic [3:0] g_rdata;

    logic       v_row_req;
    logic [3:0] v_row;
    logic       v_row_ready;
    logic [4:0] v_rd_x;
    logic [3:0] v_rd_data;

    logic [4:0] ram_x;
    logic [3:0] ram_y;
    logic [3:0] ram_in;
    logic       ram_rd;
    logic       ram_wr;
    logic [3:0] ram_out;

    modport slave (
        input  g_req, g_we, g_x, g_y, g_wdata,
        output g_ack, g_rvalid, g_rdata,
        input  v_row_req, v_row, v_rd_x,
        output v_row_ready, v_rd_data,
        output ram_x, ram_y, ram_in, ram_rd, ram_wr,
        input  ram_out
    );

    modport master (
        output g_req, g_we, g_x, g_y, g_wdata,
        input  g_ack, g_rvalid, g_rdata,
        output v_row_req, v_row, v_rd_x,
        input  v_row_ready, v_rd_data,
        input  ram_x, ram_y, ram_in, ram_rd, ram_wr,
        output ram_out
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// Arbitrates the single-port board RAM between game cell accesses (priority) and
// background row fetches for video into a double-buffered line store.
module board_ram_arbiter #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 16
) (
    input logic               clk,
    input logic               rst,
    board_ram_arbiter_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW:0] LAST_COL = (XW + 1)'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} fetch_state_t;

    fetch_state_t   state;
    logic [XW:0]    ptr;
    logic [YW-1:0]  fetch_row;
    logic [YW-1:0]  front_row;
    logic           ret_valid;
    logic [XW-1:0]  ret_col;
    logic           front_sel;
    logic           back_sel;
    logic [3:0]     line_buf [2][WIDTH];

    logic grant;
    logic fetch_issue;
    logic swap;
    logic snoop_front;
    logic snoop_back;

    // A cycle with g_ack high is never granted, leaving the following slot to video.
    assign grant       = bus.g_req && !bus.g_ack;
    assign fetch_issue = (state == FETCH) && !grant && !bus.v_row_req;
    assign swap        = (state == SWAP) && !bus.v_row_req;
    assign back_sel    = ~front_sel;

    // Snoops fire while the write is on the RAM pins, so they land on the same edge as
    // the RAM update. The back snoop stays live through SWAP: a write issued in DRAIN
    // reaches the pins after the last fetch read and must still reach the new front.
    assign snoop_front = bus.ram_wr && (bus.ram_y == front_row);
    assign snoop_back  = bus.ram_wr && (state != IDLE) && (bus.ram_y == fetch_row);

    // NOTE: synchronous reset is tested first so it overrides every other update, and all
    // sequential state uses <= so every read in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            fetch_row       <= '0;
            front_row       <= '0;
            ret_valid       <= 1'b0;
            ret_col         <= '0;
            bus.ram_x       <= '0;
            bus.ram_y       <= '0;
            bus.ram_in      <= '0;
            bus.ram_rd      <= 1'b0;
            bus.ram_wr      <= 1'b0;
            bus.g_ack       <= 1'b0;
            bus.g_rvalid    <= 1'b0;
            bus.v_row_ready <= 1'b0;
        end else begin
            bus.ram_rd      <= 1'b0;
            bus.ram_wr      <= 1'b0;
            bus.g_ack       <= 1'b0;
            bus.v_row_ready <= 1'b0;
            bus.g_rvalid    <= bus.g_ack && bus.ram_rd;
            ret_valid       <= bus.ram_rd && !bus.g_ack;
            ret_col         <= bus.ram_x;

            if (grant) begin
                bus.ram_x  <= bus.g_x;
                bus.ram_y  <= bus.g_y;
                bus.ram_in <= bus.g_wdata;
                bus.ram_rd <= !bus.g_we;
                bus.ram_wr <= bus.g_we;
                bus.g_ack  <= 1'b1;
            end else if (fetch_issue) begin
                bus.ram_x  <= ptr[XW-1:0];
                bus.ram_y  <= fetch_row;
                bus.ram_rd <= 1'b1;
            end

            // A new row request restarts the fetch from any state; the old one never swaps.
            if (bus.v_row_req) begin
                fetch_row <= bus.v_row;
                ptr       <= '0;
                state     <= FETCH;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    FETCH: begin
                        if (fetch_issue) begin
                            ptr <= ptr + 1'b1;
                            if (ptr == LAST_COL) state <= DRAIN;
                        end
                    end
                    DRAIN: state <= SWAP;
                    SWAP: begin
                        front_row       <= fetch_row;
                        bus.v_row_ready <= 1'b1;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the line store is cleared on reset because the display must see an empty
    // front row after reset, which costs a reset term on every cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                line_buf[0][i] <= '0;
                line_buf[1][i] <= '0;
            end
        end else begin
            if (ret_valid)   line_buf[back_sel][ret_col]    <= bus.ram_out;
            // Later assignment wins, so a snoop beats a fetch return to the same column.
            if (snoop_back)  line_buf[back_sel][bus.ram_x]  <= bus.ram_in;
            if (snoop_front) line_buf[front_sel][bus.ram_x] <= bus.ram_in;
            if (swap)        front_sel <= ~front_sel;
        end
    end

    assign bus.g_rdata   = bus.g_rvalid ? bus.ram_out : 4'h0;
    assign bus.v_rd_data = line_buf[front_sel][bus.v_rd_x];
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Randomised self-checking bench for board_ram_arbiter: a behavioural RAM on the pins,
// plus a board-level model (cell array + "front shows the last fetched row") for expectations.
module tb_board_ram_arbiter;
    logic clk;
    logic rst;
    board_ram_arbiter_if bus ();

    board_ram_arbiter #(.WIDTH(32), .HEIGHT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency and a preload port.
    logic [3:0] mem [16][32];
    logic [3:0] ram_q;
    logic       pre_we;
    logic [3:0] pre_y;
    logic [4:0] pre_x;
    logic [3:0] pre_d;

    always @(posedge clk) begin
        if (pre_we) mem[pre_y][pre_x] <= pre_d;
        else if (bus.ram_wr === 1'b1) mem[bus.ram_y][bus.ram_x] <= bus.ram_in;
        if (bus.ram_rd === 1'b1) ram_q <= mem[bus.ram_y][bus.ram_x];
    end
    assign bus.ram_out = ram_q;

    int ready_cnt = 0;
    always @(negedge clk) if (bus.v_row_ready === 1'b1) ready_cnt++;

    typedef struct {
        bit         we;
        logic [4:0] x;
        logic [3:0] y;
        logic [3:0] d;
    } req_t;

    req_t       req_q[$];
    logic [3:0] model_board [16][32];
    int         model_front_row;
    bit         front_empty;
    int         total;
    int         bad;

    task automatic push_req(input bit we, input int x, input int y, input int d);
        req_t r;
        r.we = we;
        r.x  = 5'(x);
        r.y  = 4'(y);
        r.d  = 4'(d);
        req_q.push_back(r);
    endtask

    task automatic push_random(input int n, input int row);
        for (int i = 0; i < n; i++)
            push_req(1'($urandom_range(0, 1)), $urandom_range(0, 31),
                     ($urandom_range(0, 1) == 1) ? row : $urandom_range(0, 15),
                     $urandom_range(0, 15));
    endtask

    // Drives queued game requests back to back and checks grant latency, grant spacing
    // and read data against the board model.
    task automatic run_game(input string tag);
        req_t       cur;
        req_t       wr;
        logic [3:0] rd_exp;
        bit         active = 0;
        bit         rd_pend = 0;
        bit         pend_w = 0;
        bit         prev_ack = 0;
        bit         ack_now;
        int         wait_cnt = 0;
        int         exp_wait = 1;
        int         guard = 0;
        rd_exp = 4'h0;
        while ((req_q.size() != 0 || active || rd_pend || pend_w) && guard < 2000) begin
            @(negedge clk);
            guard++;
            ack_now = (bus.g_ack === 1'b1);
            if (pend_w) begin
                model_board[wr.y][wr.x] = wr.d;
                pend_w = 0;
            end
            total++;
            if (prev_ack && ack_now) begin
                bad++;
                $display("FAIL %s_ack_spacing: g_ack high two cycles in a row", tag);
            end
            prev_ack = ack_now;
            total++;
            if (rd_pend) begin
                if (bus.g_rvalid !== 1'b1 || bus.g_rdata !== rd_exp) begin
                    bad++;
                    $display("FAIL %s_rdata: got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                             tag, bus.g_rvalid, bus.g_rdata, rd_exp);
                end
                rd_pend = 0;
            end else if (bus.g_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL %s_rvalid_idle: got %b want 0", tag, bus.g_rvalid);
            end
            if (active) begin
                wait_cnt++;
                if (ack_now) begin
                    total++;
                    if (wait_cnt != exp_wait) begin
                        bad++;
                        $display("FAIL %s_ack_latency: got %0d want %0d", tag, wait_cnt, exp_wait);
                    end
                    if (cur.we) begin
                        wr = cur;
                        pend_w = 1;
                    end else begin
                        rd_exp = model_board[cur.y][cur.x];
                        rd_pend = 1;
                    end
                    active = 0;
                end else if (wait_cnt > exp_wait) begin
                    total++;
                    bad++;
                    $display("FAIL %s_ack_timeout: no g_ack after %0d cycles", tag, wait_cnt);
                    bus.g_req = 1'b0;
                    active = 0;
                end
            end
            if (!active) begin
                if (req_q.size() != 0) begin
                    cur = req_q.pop_front();
                    bus.g_req   = 1'b1;
                    bus.g_we    = cur.we;
                    bus.g_x     = cur.x;
                    bus.g_y     = cur.y;
                    bus.g_wdata = cur.d;
                    exp_wait = ack_now ? 2 : 1;
                    wait_cnt = 0;
                    active = 1;
                end else begin
                    bus.g_req = 1'b0;
                end
            end
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s_game_guard: game traffic did not drain", tag);
            bus.g_req = 1'b0;
            req_q.delete();
        end
    endtask

    task automatic pulse_row_req(input int row);
        bus.v_row_req = 1'b1;
        bus.v_row     = 4'(row);
        @(negedge clk);
        bus.v_row_req = 1'b0;
    endtask

    // Called one cycle after the request; returns cycles from request to v_row_ready.
    task automatic wait_ready(input int limit, output int lat);
        lat = 1;
        while (bus.v_row_ready !== 1'b1 && lat <= limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_front(input string tag);
        logic [3:0] exp;
        for (int i = 0; i < 32; i++) begin
            bus.v_rd_x = 5'(i);
            #1;
            exp = front_empty ? 4'h0 : model_board[model_front_row][i];
            total++;
            if (bus.v_rd_data !== exp) begin
                bad++;
                $display("FAIL %s_front x=%0d: got %h want %h", tag, i, bus.v_rd_data, exp);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({bus.g_ack, bus.g_rvalid, bus.g_rdata, bus.v_row_ready, bus.ram_x, bus.ram_y,
             bus.ram_in, bus.ram_rd, bus.ram_wr} !== 27'h0) begin
            bad++;
            $display("FAIL %s_outputs: ack=%b rvalid=%b rdata=%h ready=%b x=%h y=%h in=%h rd=%b wr=%b want all 0",
                     tag, bus.g_ack, bus.g_rvalid, bus.g_rdata, bus.v_row_ready, bus.ram_x,
                     bus.ram_y, bus.ram_in, bus.ram_rd, bus.ram_wr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 32; x++) begin
                @(negedge clk);
                pre_we = 1'b1;
                pre_y  = 4'(y);
                pre_x  = 5'(x);
                pre_d  = (y == 9) ? 4'(x % 16) : 4'($urandom_range(0, 15));
                model_board[y][x] = pre_d;
            end
        end
        @(negedge clk);
        pre_we = 1'b0;
        front_empty = 1;
        check_reset_outputs("reset");
        check_front("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_idle_fetch();
        int lat;
        pulse_row_req(9);
        wait_ready(40, lat);
        total++;
        if (lat != 35) begin
            bad++;
            $display("FAIL idle_fetch_latency: got %0d want 35", lat);
        end
        model_front_row = 9;
        front_empty = 0;
        bus.v_rd_x = 5'd17;
        #1;
        total++;
        if (bus.v_rd_data !== 4'h1) begin
            bad++;
            $display("FAIL idle_fetch_x17: got %h want 1", bus.v_rd_data);
        end
        check_front("idle_fetch");
    endtask

    task automatic test_write_read();
        push_req(1'b1, 3, 4, 15);
        push_req(1'b0, 3, 4, 0);
        run_game("write_read");
        total++;
        if (model_board[4][3] !== 4'hF) begin
            bad++;
            $display("FAIL write_read_model: got %h want f", model_board[4][3]);
        end
        push_random(8, 4);
        push_req(1'b0, 3, 4, 0);
        run_game("random_access");
    endtask

    task automatic test_snoop();
        int         lat;
        logic [3:0] d;
        fork
            begin
                pulse_row_req(5);
                wait_ready(70, lat);
            end
            begin
                repeat (2) @(negedge clk);
                push_req(1'b1, 31, 5, 2);
                run_game("snoop_31");
                repeat (6) @(negedge clk);
                push_req(1'b1, 0, 5, 8);
                run_game("snoop_0");
            end
        join
        total++;
        if (lat > 67) begin
            bad++;
            $display("FAIL snoop_fetch_latency: got %0d want <=67", lat);
        end
        model_front_row = 5;
        bus.v_rd_x = 5'd31;
        #1;
        total++;
        if (bus.v_rd_data !== 4'h2) begin
            bad++;
            $display("FAIL snoop_x31: got %h want 2", bus.v_rd_data);
        end
        bus.v_rd_x = 5'd0;
        #1;
        total++;
        if (bus.v_rd_data !== 4'h8) begin
            bad++;
            $display("FAIL snoop_x0: got %h want 8", bus.v_rd_data);
        end
        check_front("snoop");
        d = 4'($urandom_range(0, 15));
        push_req(1'b1, 10, 5, int'(d));
        run_game("front_write");
        bus.v_rd_x = 5'd10;
        #1;
        total++;
        if (bus.v_rd_data !== d) begin
            bad++;
            $display("FAIL front_write_update: got %h want %h", bus.v_rd_data, d);
        end
    endtask

    task automatic test_contention();
        int lat;
        int row;
        row = $urandom_range(0, 15);
        push_random(40, row);
        fork
            begin
                pulse_row_req(row);
                wait_ready(67, lat);
            end
            run_game("contention");
        join
        total++;
        if (lat > 67) begin
            bad++;
            $display("FAIL contention_latency: got %0d want <=67", lat);
        end
        model_front_row = row;
        check_front("contention");
    endtask

    task automatic test_abort();
        int lat;
        int cnt0;
        cnt0 = ready_cnt;
        pulse_row_req(2);
        repeat (9) @(negedge clk);
        pulse_row_req(7);
        wait_ready(40, lat);
        total++;
        if (lat != 35) begin
            bad++;
            $display("FAIL abort_latency: got %0d want 35", lat);
        end
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (ready_cnt - cnt0 != 1) begin
            bad++;
            $display("FAIL abort_ready_count: got %0d want 1", ready_cnt - cnt0);
        end
        model_front_row = 7;
        check_front("abort");
    endtask

    task automatic test_reset_mid_fetch();
        int lat;
        int cnt0;
        cnt0 = ready_cnt;
        pulse_row_req(11);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_fetch_reset");
        front_empty = 1;
        check_front("mid_fetch_reset");
        rst = 1'b0;
        repeat (45) @(negedge clk);
        #1;
        total++;
        if (ready_cnt != cnt0) begin
            bad++;
            $display("FAIL mid_fetch_no_ready: got %0d pulses want 0", ready_cnt - cnt0);
        end
        check_reset_outputs("after_reset_idle");
        check_front("after_reset_empty");
        pulse_row_req(11);
        wait_ready(40, lat);
        total++;
        if (lat != 35) begin
            bad++;
            $display("FAIL recover_latency: got %0d want 35", lat);
        end
        model_front_row = 11;
        front_empty = 0;
        check_front("recover");
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        pre_we = 1'b0;
        pre_x = '0;
        pre_y = '0;
        pre_d = '0;
        bus.g_req = 1'b0;
        bus.g_we = 1'b0;
        bus.g_x = '0;
        bus.g_y = '0;
        bus.g_wdata = '0;
        bus.v_row_req = 1'b0;
        bus.v_row = '0;
        bus.v_rd_x = '0;
        model_front_row = 0;
        front_empty = 1;

        test_reset();
        test_idle_fetch();
        test_write_read();
        test_snoop();
        test_contention();
        test_abort();
        test_reset_mid_fetch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
